seq_chunk_add: RTL and testbench
================================

# seq_chunk_add

Parametrised, multi-cycle adder/subtractor that processes WIDTH-bit operands CHUNK bits per clock, LSB chunk first, through a CHUNK-bit ripple chain of full adders with a registered carry between chunks. It sits behind the team's single-bit full adder as the reusable arithmetic unit for datapaths that trade latency for area. Operands and results move over valid/ready handshakes. Signed overflow and subtract mode are provided.

## Interface
- WIDTH, 16: operand/result width in bits; ≥1.
- CHUNK, 4: bits added per RUN cycle; 1 ≤ CHUNK ≤ WIDTH; WIDTH % CHUNK must be 0 (elaboration error otherwise). NCHUNK = WIDTH/CHUNK.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (borrow-in when sub=1).
- sub  in  1  0: a+b+cin; 1: a−b−cin.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- cout  out  1  carry out of MSB (sub=1: 1 = no borrow).
- ovf  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready at an edge: latch a, b_eff = sub ? ~b : b, carry = sub ^ cin; clear chunk counter k=0; go RUN. Other inputs ignored while not in IDLE.
- RUN: each edge adds a[k*CHUNK +: CHUNK] + b_eff[same] + carry; writes sum[k*CHUNK +: CHUNK]; carry ← chunk carry-out; k ← k+1. On the edge processing k=NCHUNK−1: capture cout = final carry, ovf = carry into MSB XOR carry out of MSB; go DONE.
- DONE: out_valid=1; sum/cout/ovf held stable. On out_valid&&out_ready at an edge → IDLE.
- sum/cout/ovf are registered; contents meaningful only while out_valid=1. In IDLE they keep the last result; in RUN sum is partially overwritten.
- No overlap: a new operation is not accepted in the same edge a result is consumed.
- CHUNK=WIDTH: RUN lasts exactly one cycle. CHUNK=1: pure bit-serial.
- Asynchronous reset at any time (including mid-RUN or in DONE): state→IDLE, k, carry, operand registers, sum, cout, ovf, out_valid → 0 immediately; in-flight operation discarded, no result emitted.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, sum=0, cout=0, ovf=0.
- in_ready and out_valid are decoded directly from state registers (no combinational path from in_valid/out_ready).
- Accept at edge T → RUN during cycles T..T+NCHUNK−1 → out_valid high from edge T+NCHUNK.
- Latency accept-to-out_valid: NCHUNK cycles. Minimum initiation interval: NCHUNK+2 cycles (out_ready held high).
- Back-pressure: DONE held indefinitely while out_ready=0; outputs bit-stable.
- Combinational depth per cycle: CHUNK full-adder stages.

## Test plan
- WIDTH=1, CHUNK=1, sub=0, all 8 (a,b,cin) combinations → sum/cout match full-adder truth table ((1,1,1)→cout=1,sum=1; (0,1,1)→cout=1,sum=0), out_valid exactly 1 cycle after accept.
- WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, ovf=0; out_valid rises 4 edges after accept, in_ready=0 throughout RUN/DONE.
- WIDTH=16, CHUNK=4: a=0x7FFF, b=0x0001, cin=0 → sum=0x8000, cout=0, ovf=1; repeat with CHUNK=16 → same result, latency 1; CHUNK=1 → latency 16.
- Subtract: a=0x0005, b=0x0007, cin=0, sub=1 → sum=0xFFFE, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, cout=1, ovf=1.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands → sum/cout/ovf unchanged, in_ready=0, new operands not accepted; raise out_ready → IDLE next cycle, then new operands accepted.
- Reset mid-RUN: assert rst_n=0 at k=2 → out_valid, sum, cout, ovf read 0 immediately, in_ready=1; after release, fresh 0x1234+0x1111 → sum=0x2345 with no stale result emitted.

Source files
------------

// File: rtl/seq_chunk_add_if.sv
// Handshake bundle for seq_chunk_add: operand request channel and result channel.
interface seq_chunk_add_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Producer/consumer side of the adder
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // The adder itself
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/seq_chunk_add.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per
// cycle, LSB chunk first, with the carry registered between chunks.
module seq_chunk_add #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_chunk_add_if.slave   bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned IW     = $clog2(WIDTH) + 1;

  // Reject chunk sizes that do not tile the operand exactly
  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("seq_chunk_add: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  // One-hot so in_ready/out_valid come straight off a flop
  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RUN  = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [KW-1:0]      r_k;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic [IW-1:0]      w_base;
  logic [CHUNK-1:0]   w_a_chunk;
  logic [CHUNK-1:0]   w_b_chunk;
  logic [CHUNK-1:0]   w_chunk_sum;
  logic               w_c;
  logic               w_msb_cin;

  assign w_last = (r_k == KW'(NCHUNK - 1));
  assign w_base = IW'(r_k) * IW'(CHUNK);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid)  w_state_nxt = S_RUN;
      S_RUN:   if (w_last)        w_state_nxt = S_DONE;
      S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
      default:                    w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath controls decoded from state
  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    unique case (r_state)
      S_IDLE:  w_load = bus.in_valid;
      S_RUN:   w_step = 1'b1;
      default: ;
    endcase
  end

  // CHUNK-stage ripple of full adders; also exposes the carry into the chunk MSB
  always_comb begin
    w_a_chunk   = r_a[w_base +: CHUNK];
    w_b_chunk   = r_b[w_base +: CHUNK];
    w_chunk_sum = '0;
    w_c         = r_carry;
    w_msb_cin   = 1'b0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      w_msb_cin      = w_c;
      w_chunk_sum[i] = w_a_chunk[i] ^ w_b_chunk[i] ^ w_c;
      w_c            = (w_a_chunk[i] & w_b_chunk[i]) | (w_c & (w_a_chunk[i] ^ w_b_chunk[i]));
    end
  end

  // Operand capture, per-chunk accumulation and final flag capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a     <= bus.a;
      r_b     <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.sub ^ bus.cin;
      r_k     <= '0;
    end else if (w_step) begin
      r_sum[w_base +: CHUNK] <= w_chunk_sum;
      r_carry                <= w_c;
      r_k                    <= w_last ? '0 : r_k + KW'(1);
      if (w_last) begin
        r_cout <= w_c;
        r_ovf  <= w_c ^ w_msb_cin;
      end
    end
  end

  assign bus.in_ready  = r_state[0];
  assign bus.out_valid = r_state[2];
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_seq_chunk_add.sv
// Self-checking bench: four seq_chunk_add configurations driven in lockstep
// and compared against an arithmetic reference model.
module tb_seq_chunk_add;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  int n_tests = 0;
  int n_fail  = 0;

  // DUT order everywhere: 0=w1 (W1/C1), 1=c1 (W16/C1), 2=c4 (W16/C4), 3=c16 (W16/C16)
  int    lat_exp [4] = '{1, 16, 4, 1};
  string nm      [4] = '{"w1", "c1", "c4", "c16"};

  always #5 clk = ~clk;

  seq_chunk_add_if #(.WIDTH(1))  bus_w1 ();
  seq_chunk_add_if #(.WIDTH(16)) bus_c1 ();
  seq_chunk_add_if #(.WIDTH(16)) bus_c4 ();
  seq_chunk_add_if #(.WIDTH(16)) bus_c16 ();

  assign bus_w1.in_valid  = in_valid;
  assign bus_w1.a         = a[0];
  assign bus_w1.b         = b[0];
  assign bus_w1.cin       = cin;
  assign bus_w1.sub       = sub;
  assign bus_w1.out_ready = out_ready;

  assign bus_c1.in_valid  = in_valid;
  assign bus_c1.a         = a;
  assign bus_c1.b         = b;
  assign bus_c1.cin       = cin;
  assign bus_c1.sub       = sub;
  assign bus_c1.out_ready = out_ready;

  assign bus_c4.in_valid  = in_valid;
  assign bus_c4.a         = a;
  assign bus_c4.b         = b;
  assign bus_c4.cin       = cin;
  assign bus_c4.sub       = sub;
  assign bus_c4.out_ready = out_ready;

  assign bus_c16.in_valid  = in_valid;
  assign bus_c16.a         = a;
  assign bus_c16.b         = b;
  assign bus_c16.cin       = cin;
  assign bus_c16.sub       = sub;
  assign bus_c16.out_ready = out_ready;

  seq_chunk_add #(.WIDTH(1),  .CHUNK(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(bus_w1));
  seq_chunk_add #(.WIDTH(16), .CHUNK(1))  u_c1  (.clk(clk), .rst_n(rst_n), .bus(bus_c1));
  seq_chunk_add #(.WIDTH(16), .CHUNK(4))  u_c4  (.clk(clk), .rst_n(rst_n), .bus(bus_c4));
  seq_chunk_add #(.WIDTH(16), .CHUNK(16)) u_c16 (.clk(clk), .rst_n(rst_n), .bus(bus_c16));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {cout, ovf, sum} from plain integer arithmetic at width w
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c, input logic s, input int w);
    int unsigned m, ml, xx, yy, be, c0, full, lo, co, cm;
    m    = (32'd1 << w) - 32'd1;
    ml   = (32'd1 << (w - 1)) - 32'd1;
    xx   = 32'(x) & m;
    yy   = 32'(y) & m;
    be   = s ? (~yy & m) : yy;
    c0   = 32'(s ^ c);
    full = xx + be + c0;
    lo   = (xx & ml) + (be & ml) + c0;
    co   = (full >> w) & 32'd1;
    cm   = (lo >> (w - 1)) & 32'd1;
    return {co[0], co[0] ^ cm[0], 16'(full & m)};
  endfunction

  function automatic logic [3:0] ready_vec();
    return {bus_c16.in_ready, bus_c4.in_ready, bus_c1.in_ready, bus_w1.in_ready};
  endfunction

  function automatic logic [3:0] valid_vec();
    return {bus_c16.out_valid, bus_c4.out_valid, bus_c1.out_valid, bus_w1.out_valid};
  endfunction

  function automatic logic [17:0] res(input int i);
    case (i)
      0:       return {bus_w1.cout, bus_w1.ovf, 15'd0, bus_w1.sum};
      1:       return {bus_c1.cout, bus_c1.ovf, bus_c1.sum};
      2:       return {bus_c4.cout, bus_c4.ovf, bus_c4.sum};
      default: return {bus_c16.cout, bus_c16.ovf, bus_c16.sum};
    endcase
  endfunction

  // One transaction on all DUTs; hold>0 keeps them in DONE while new operands are offered
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv,
                        input logic tc, input logic ts, input int hold);
    logic [17:0] exp [4];
    int          lat [4];
    logic [3:0]  seen;
    logic [3:0]  v;
    for (int i = 0; i < 4; i++) begin
      exp[i] = model(ta, tbv, tc, ts, (i == 0) ? 1 : 16);
      lat[i] = 0;
    end
    @(negedge clk);
    a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    check("in_ready_idle", 32'(ready_vec()), 32'hF);
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = '0;
    for (int n = 1; n <= 40 && seen != 4'hF; n++) begin
      @(posedge clk); #1;
      check("in_ready_busy", 32'(ready_vec()), 32'h0);
      v = valid_vec();
      for (int i = 0; i < 4; i++) begin
        if (!seen[i] && v[i]) begin
          seen[i] = 1'b1;
          lat[i]  = n;
        end
      end
    end
    check("done_timeout", 32'(seen), 32'hF);
    for (int i = 0; i < 4; i++) begin
      check({"latency_", nm[i]}, 32'(lat[i]), 32'(lat_exp[i]));
      check({"result_", nm[i]}, 32'(res(i)), 32'(exp[i]));
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a   = 16'($urandom);
      b   = 16'($urandom);
      cin = 1'($urandom);
      sub = 1'($urandom);
      @(posedge clk); #1;
      check("bp_in_ready", 32'(ready_vec()), 32'h0);
      check("bp_out_valid", 32'(valid_vec()), 32'hF);
      for (int i = 0; i < 4; i++) check({"bp_stable_", nm[i]}, 32'(res(i)), 32'(exp[i]));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("consume_out_valid", 32'(valid_vec()), 32'h0);
    check("consume_in_ready", 32'(ready_vec()), 32'hF);
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ta;
    logic [15:0] tbv;
    logic [2:0]  tt;

    // Reset values
    #12;
    check("rst_in_ready", 32'(ready_vec()), 32'hF);
    check("rst_out_valid", 32'(valid_vec()), 32'h0);
    for (int i = 0; i < 4; i++) check({"rst_result_", nm[i]}, 32'(res(i)), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full-adder truth table through the 1-bit instance
    for (int i = 0; i < 8; i++) begin
      tt     = 3'(i);
      ta     = 16'($urandom);
      tbv    = 16'($urandom);
      ta[0]  = tt[2];
      tbv[0] = tt[1];
      run_op(ta, tbv, tt[0], 1'b0, 0);
    end

    // Directed corner values
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    check("dir_ffff_plus_1", 32'(res(2)), 32'({1'b1, 1'b0, 16'h0000}));
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
    check("dir_7fff_plus_1_c4", 32'(res(2)), 32'({1'b0, 1'b1, 16'h8000}));
    check("dir_7fff_plus_1_c16", 32'(res(3)), 32'({1'b0, 1'b1, 16'h8000}));
    check("dir_7fff_plus_1_c1", 32'(res(1)), 32'({1'b0, 1'b1, 16'h8000}));
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 0);
    check("dir_5_minus_7", 32'(res(2)), 32'({1'b0, 1'b0, 16'hFFFE}));
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 0);
    check("dir_8000_minus_1", 32'(res(2)), 32'({1'b1, 1'b1, 16'h7FFF}));

    // Back-pressure with new operands offered while in DONE
    run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 10);

    // Random traffic
    for (int i = 0; i < 30; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    // Reset mid-RUN (CHUNK=4 instance at k=2)
    @(negedge clk);
    a = 16'hABCD; b = 16'h1357; cin = 1'b1; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("midrun_out_valid", 32'(valid_vec()), 32'h0);
    check("midrun_in_ready", 32'(ready_vec()), 32'hF);
    for (int i = 0; i < 4; i++) check({"midrun_result_", nm[i]}, 32'(res(i)), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);
    check("post_reset_sum", 32'(res(2)), 32'({1'b0, 1'b0, 16'h2345}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
